// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: RAW hazards, branch flush, memory waits.
// Build macro FORWARDING_EN narrows RAW hazards to EXE-stage load-use.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_src1,
    input  logic [3:0]  id_src2,
    input  logic        id_use_src1,
    input  logic        id_two_src,
    input  logic        exe_wb_en,
    input  logic        exe_mem_read,
    input  logic [3:0]  exe_dest,
    input  logic        mem_wb_en,
    input  logic [3:0]  mem_dest,
    input  logic        branch_taken,
    input  logic        mem_access,
    input  logic        mem_ready,
    output logic        pc_freeze,
    output logic        if_id_freeze,
    output logic        id_exe_freeze,
    output logic        exe_mem_freeze,
    output logic        if_id_flush,
    output logic        id_exe_flush,
    output logic        mem_wb_flush,
    output logic        mem_req,
    output logic        mem_error,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    localparam logic [CNT_W:0] TMO = (CNT_W+1)'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W:0]   wait_inc;
    logic             mem_error_q, mem_error_d;
    logic [15:0]      stall_cnt_q, stall_cnt_d;
    logic [15:0]      flush_cnt_q, flush_cnt_d;
    logic             src1_hit, src2_hit, hazard;
    logic             freeze_all, req_o, br_flush, haz_stall;

`ifdef FORWARDING_EN
    assign src1_hit = exe_mem_read && exe_wb_en && (exe_dest == id_src1);
    assign src2_hit = exe_mem_read && exe_wb_en && (exe_dest == id_src2);
    logic unused_mem_stage;
    assign unused_mem_stage = ^{mem_wb_en, mem_dest};
`else
    assign src1_hit = (exe_wb_en && (exe_dest == id_src1)) ||
                      (mem_wb_en && (mem_dest == id_src1));
    assign src2_hit = (exe_wb_en && (exe_dest == id_src2)) ||
                      (mem_wb_en && (mem_dest == id_src2));
    logic unused_mem_read;
    assign unused_mem_read = exe_mem_read;
`endif

    assign hazard = (id_use_src1 && src1_hit) || (id_two_src && src2_hit);

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = '0;
        mem_error_d = mem_error_q;
        freeze_all  = 1'b0;
        req_o       = 1'b0;
        br_flush    = 1'b0;
        haz_stall   = 1'b0;
        wait_inc    = {1'b0, wait_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
        unique case (state_q)
            ST_FAULT: freeze_all = 1'b1;
            ST_WAIT: begin
                if (!mem_ready) begin
                    freeze_all = 1'b1;
                    req_o      = 1'b1;
                    wait_cnt_d = wait_inc[CNT_W-1:0];
                    if (wait_inc >= TMO) begin
                        state_d     = ST_FAULT;
                        mem_error_d = 1'b1;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                if (mem_access && !mem_ready) begin
                    freeze_all = 1'b1;
                    req_o      = 1'b1;
                    state_d    = ST_WAIT;
                end
            end
        endcase
        // Pipeline is free to advance: branch beats hazard.
        if (!freeze_all) begin
            req_o     = mem_access;
            br_flush  = branch_taken;
            haz_stall = hazard && !branch_taken;
        end
        if (rst) begin
            freeze_all = 1'b0;
            req_o      = 1'b0;
            br_flush   = 1'b0;
            haz_stall  = 1'b0;
        end
    end

    assign pc_freeze      = freeze_all | haz_stall;
    assign if_id_freeze   = freeze_all | haz_stall;
    assign id_exe_freeze  = freeze_all;
    assign exe_mem_freeze = freeze_all;
    assign if_id_flush    = br_flush;
    assign id_exe_flush   = br_flush | haz_stall;
    assign mem_wb_flush   = freeze_all;
    assign mem_req        = req_o;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_freeze && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
        if (if_id_flush && flush_cnt_q != 16'hFFFF)
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            mem_error_q <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign state     = state_q;
    assign mem_error = mem_error_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage ARM pipeline (IF, ID, EXE, MEM, WB). It drives the freeze and flush inputs of the PC and the IF/ID, ID/EX, EXE/MEM and MEM/WB stage registers. It resolves RAW hazards, taken-branch flushes and multi-cycle data-memory accesses, and has a timeout fault state. Saturating counters record stall and flush activity for lab performance reporting.

## Interface
- MEM_TIMEOUT, 255: max cycles in WAIT without mem_ready before fault (1..2^CNT_W-1)
- CNT_W, 8: width of the wait counter
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- id_src1, id_src2  in  4  ID-stage source register numbers (Rn, Rm/Rd)
- id_use_src1  in  1  instruction in ID reads id_src1
- id_two_src  in  1  instruction in ID reads id_src2
- exe_wb_en, exe_mem_read  in  1  ID/EX register outputs: wb_en, mem_read_en
- exe_dest  in  4  ID/EX register dest
- mem_wb_en  in  1  EXE/MEM wb_en
- mem_dest  in  4  EXE/MEM dest
- branch_taken  in  1  EXE-stage branch resolved taken (B and condition passed)
- mem_access  in  1  MEM-stage instruction does a read or write
- mem_ready  in  1  data memory completes the current access this cycle
- pc_freeze, if_id_freeze, id_exe_freeze, exe_mem_freeze  out  1  hold register
- if_id_flush, id_exe_flush, mem_wb_flush  out  1  load bubble into register
- mem_req  out  1  data-memory request level
- mem_error  out  1  sticky timeout fault
- state  out  2  RUN=0, WAIT=1, FAULT=2
- stall_cnt, flush_cnt  out  16  saturating performance counters

## Operation
- Hazard (raw): (id_use_src1 and src1 match) or (id_two_src and src2 match). A source matches on (exe_wb_en and exe_dest==src) or (mem_wb_en and mem_dest==src).
- RUN, mem_access=0 or mem_ready=1: memory does not stall.
  - branch_taken: if_id_flush=id_exe_flush=1, no freeze; any hazard is ignored.
  - else hazard: pc_freeze=if_id_freeze=1, id_exe_flush=1 (bubble into EXE).
  - else all outputs 0.
- RUN, mem_access=1, mem_ready=0: full freeze. PC, IF/ID, ID/EX and EXE/MEM are held, mem_wb_flush=1, mem_req=1, and the next state is WAIT. Branch and hazard outputs are suppressed.
- WAIT: full freeze, mem_wb_flush=1 and mem_req=1 hold while mem_ready=0. The wait counter increments each cycle.
  - mem_ready=1 removes all freezes in that same cycle, so the pipeline advances on that edge, and the next state is RUN. Branch and hazard logic then applies in that cycle, as in RUN.
  - If the counter reaches MEM_TIMEOUT while mem_ready=0, the next state is FAULT.
- FAULT: full freeze, mem_wb_flush=1, mem_req=0 and mem_error=1. The block leaves FAULT only on rst.
- In RUN, mem_req=mem_access.
- The wait counter clears on every entry to WAIT and while in RUN.
- stall_cnt increments on every cycle with pc_freeze=1, including memory stalls and FAULT.
- flush_cnt increments on every cycle with branch flush asserted.
- Both counters saturate at 16'hFFFF.

## Timing
- While rst is high and after reset: state=RUN, counters=0 and mem_error=0. Every freeze, flush and mem_req output is 0 while rst is high.
- Freeze, flush and mem_req are combinational from the inputs and the current state, so they act at the very next edge. state, counters and mem_error are registered.
- Load-use stall is 1 cycle with forwarding, and up to 2 cycles without forwarding.
- A single-cycle memory access (mem_ready=1 in RUN) adds no stall.
- An N-cycle access (mem_ready arrives N-1 cycles after entry) costs N-1 frozen cycles.
- Simultaneous events: rst > FAULT > memory stall > branch flush > hazard stall.
- rst during WAIT aborts the access immediately: mem_req goes 0 asynchronously.

## Configuration
- FORWARDING_EN defined: the forwarding unit covers EXE/MEM results.
  - Hazard requires exe_mem_read=1 and an EXE-stage match only.
  - MEM-stage matches are ignored.
- FORWARDING_EN undefined: the full hazard rule above applies, with EXE and MEM matches and no mem_read qualifier.

## Test plan
- Hazard, no forwarding: exe_wb_en=1, exe_dest=3, id_src1=3, id_use_src1=1 -> pc_freeze=if_id_freeze=id_exe_flush=1, stall_cnt goes 0->1.
- Load-use with FORWARDING_EN: exe_mem_read=1, exe_dest=5, id_src2=5, id_two_src=1 -> 1-cycle stall. Same case with exe_mem_read=0 -> no stall.
- Branch plus hazard in one cycle: branch_taken=1 with a matching dest -> if_id_flush=id_exe_flush=1, pc_freeze=0, flush_cnt=1.
- Memory wait: mem_access=1, mem_ready low for 3 cycles then high -> state RUN,WAIT,WAIT,WAIT then RUN; mem_req high for 4 cycles; freeze released in the mem_ready cycle.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> FAULT after 4 WAIT cycles, mem_error=1, mem_req=0. Asserting rst returns state=0 and mem_error=0.
- Saturation: force 70000 hazard cycles -> stall_cnt=16'hFFFF and it stays there.
